// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - instruction fetch request FSM with a small FIFO prefetch queue toward decode
module fetch_prefetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       imem_req_valid,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_req_ready,
  input  logic                       imem_rsp_valid,
  input  logic [31:0]                imem_rsp_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_pc_plus_four,
  output logic [31:0]                out_instr,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t            state, state_nx;
  logic [XLEN-1:0]   fetch_pc, req_pc;
  logic [XLEN-1:0]   pc_mem    [DEPTH];
  logic [31:0]       instr_mem [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;
  logic              has_data, accept, push, pop;

  // Issue only with a free slot, so the single outstanding response always fits.
  assign has_data       = (count != '0);
  assign imem_req_valid = rst && (state == S_IDLE) && (count < FULL) && !redirect_valid;
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign push           = (state == S_WAIT) && imem_rsp_valid && !redirect_valid;
  assign out_valid      = has_data && !redirect_valid;
  assign pop            = out_valid && out_ready;
  assign occupancy      = count;

  assign out_pc           = has_data ? pc_mem[head] : '0;
  assign out_pc_plus_four = has_data ? pc_mem[head] + XLEN'(4) : '0;
  assign out_instr        = has_data ? instr_mem[head] : '0;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = S_WAIT;
      // A response coinciding with a redirect retires the request without pushing.
      S_WAIT: begin
        if (imem_rsp_valid)      state_nx = S_IDLE;
        else if (redirect_valid) state_nx = S_DROP;
      end
      S_DROP: if (imem_rsp_valid) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      state <= state_nx;
      if (accept) req_pc <= fetch_pc;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
      end else begin
        if (accept) fetch_pc <= fetch_pc + XLEN'(4);
        if (push)   tail     <= tail + PTR_W'(1);
        if (pop)    head     <= head + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]    <= req_pc;
      instr_mem[tail] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb/tb_fetch_prefetch_unit.sv - directed self-checking bench for fetch_prefetch_unit
module tb_fetch_prefetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus_four;
  logic [31:0] out_instr;
  logic [2:0]  occupancy;

  int n_assert = 0;
  int n_fail   = 0;

  fetch_prefetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .imem_req_valid   (imem_req_valid),
    .imem_req_addr    (imem_req_addr),
    .imem_req_ready   (imem_req_ready),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_pc           (out_pc),
    .out_pc_plus_four (out_pc_plus_four),
    .out_instr        (out_instr),
    .occupancy        (occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_occ", occupancy, 0);
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_pc4", out_pc_plus_four, 0);
    check("rst_instr", out_instr, 0);

    // Streaming fetch, response one cycle after accept, decode always ready
    rst = 1'b1; imem_req_ready = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      imem_rsp_valid = 1'b0;
      #1;
      check("stream_req_valid", imem_req_valid, 1);
      check("stream_req_addr", imem_req_addr, 4 * i);
      if (i > 0) begin
        check("stream_out_valid", out_valid, 1);
        check("stream_out_pc", out_pc, 4 * (i - 1));
        check("stream_pc4", out_pc_plus_four, 4 * i);
        check("stream_instr", out_instr, instr_of(32'(4 * (i - 1))));
      end
      tick();
      imem_rsp_valid = 1'b1; imem_rsp_data = instr_of(32'(4 * i));
      #1;
      check("stream_wait_no_req", imem_req_valid, 0);
      tick();
    end
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b0;
    #1;
    check("stream_last_pc", out_pc, 32'hC);
    check("stream_last_pc4", out_pc_plus_four, 32'h10);
    tick();

    // Decode stalled: queue fills, issue stops, head holds
    redirect_valid = 1'b1; redirect_pc = 32'h0; out_ready = 1'b0;
    #1;
    check("redir_blocks_req", imem_req_valid, 0);
    tick();
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      imem_rsp_valid = 1'b0;
      #1;
      check("fill_occ", occupancy, i);
      if (i > 0) check("fill_head_pc", out_pc, 0);
      tick();
      imem_rsp_valid = 1'b1; imem_rsp_data = instr_of(32'(4 * i));
      tick();
    end
    imem_rsp_valid = 1'b0;
    #1;
    check("full_occ", occupancy, 4);
    check("full_no_req", imem_req_valid, 0);
    check("full_head_pc", out_pc, 0);
    check("full_head_instr", out_instr, instr_of(32'h0));
    tick();
    check("full_hold_pc", out_pc, 0);

    // Push and pop together at occupancy DEPTH-1
    out_ready = 1'b1; imem_req_ready = 1'b0;
    tick();
    out_ready = 1'b0; imem_req_ready = 1'b1;
    #1;
    check("refill_addr", imem_req_addr, 32'h10);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = instr_of(32'h10); out_ready = 1'b1;
    #1;
    check("pushpop_head", out_pc, 32'h4);
    tick();
    imem_rsp_valid = 1'b0; out_ready = 1'b0; imem_req_ready = 1'b0;
    #1;
    check("pushpop_occ", occupancy, 3);
    check("pushpop_next_head", out_pc, 32'h8);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("drain_pc", out_pc, 32'h8 + 4 * i);
      tick();
    end
    check("drain_occ", occupancy, 0);
    check("drain_out_valid", out_valid, 0);

    // Redirect while a request is outstanding; late response dropped
    imem_req_ready = 1'b1; out_ready = 1'b0;
    #1;
    check("pre_redir_addr", imem_req_addr, 32'h14);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    #1;
    check("redir_wait_no_req", imem_req_valid, 0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("drop_no_req", imem_req_valid, 0);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    check("drop_occ", occupancy, 0);
    check("drop_out_valid", out_valid, 0);
    check("drop_req_valid", imem_req_valid, 1);
    check("drop_next_addr", imem_req_addr, 32'h100);
    tick();

    // Redirect coinciding with the response
    redirect_valid = 1'b1; redirect_pc = 32'h200; imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hCAFE_F00D; imem_req_ready = 1'b0;
    tick();
    redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
    #1;
    check("same_occ", occupancy, 0);
    check("same_req_valid", imem_req_valid, 1);
    check("same_next_addr", imem_req_addr, 32'h200);

    // PC wrap at 2^32
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    #1;
    check("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = instr_of(32'hFFFF_FFFC);
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    check("wrap_out_pc", out_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", out_pc_plus_four, 32'h0);
    check("wrap_next_addr", imem_req_addr, 32'h0);
    check("wrap_occ", occupancy, 1);

    // Reset in WAIT, then a stale response
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    #1;
    check("wait_before_rst", imem_req_valid, 0);
    rst = 1'b0;
    #1;
    check("midrst_occ", occupancy, 0);
    check("midrst_req_valid", imem_req_valid, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_pc", out_pc, 0);
    tick();
    rst = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    check("stale_occ", occupancy, 0);
    check("stale_out_valid", out_valid, 0);
    check("stale_req_valid", imem_req_valid, 1);
    check("stale_next_addr", imem_req_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
